// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op codes, FSM encoding and iteration count for muldiv_ctrl (MULDIV_ITER_MUL_EN adds the MUL state)
package muldiv_pkg;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    // Codes 0 and 7 are NOPs.
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

`ifdef MULDIV_ITER_MUL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2, S_MUL = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;
`endif

    function automatic logic is_valid_op(input logic [2:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - unsigned radix-2 restoring divider, one quotient bit per step
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient_next,
    output logic [WIDTH-1:0] remainder_next,
    output logic             last
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    assign last = (cnt_q == '0);

    // Trial subtraction; a zero divisor always succeeds, giving all-ones quotient and remainder = dividend.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
        if (!diff[WIDTH]) begin
            remainder_next = diff[WIDTH-1:0];
            quotient_next  = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            remainder_next = shifted[WIDTH-1:0];
            quotient_next  = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Partial remainder, quotient shift register and iteration counter (31 down to 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= CNT_W'(ITER_COUNT - 1);
        end else if (step) begin
            rem_q <= remainder_next;
            quo_q <= quotient_next;
            if (cnt_q != '0)
                cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide controller; MULDIV_ITER_MUL_EN selects a 32-cycle shift-add multiplier
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic [1:0]       we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic             quo_neg_q, rem_neg_q, div_zero_q;
    logic [WIDTH-1:0] res_hi_q, res_lo_q;

    logic             accept, a_neg, b_neg, multi_op, busy;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] quo_next, rem_next;
    logic             div_last;

    assign accept   = (state_q == S_IDLE) && start_i && !cancel_i && is_valid_op(op_i);
    assign a_neg    = is_signed_op(op_i) && a_i[WIDTH-1];
    assign b_neg    = is_signed_op(op_i) && b_i[WIDTH-1];
    assign mag_a    = a_neg ? -a_i : a_i;
    assign mag_b    = b_neg ? -b_i : b_i;
    assign hi_o     = res_hi_q;
    assign lo_o     = res_lo_q;

`ifdef MULDIV_ITER_MUL_EN
    logic [2*WIDTH-1:0] mul_acc_q, mul_mcand_q, mul_acc_next;
    logic [WIDTH-1:0]   mul_mplier_q;
    logic [CNT_W-1:0]   mul_cnt_q;
    logic               mul_last;

    assign mul_last     = (mul_cnt_q == '0);
    assign mul_acc_next = mul_mplier_q[0] ? mul_acc_q + mul_mcand_q : mul_acc_q;
    assign multi_op     = is_div_op(op_i) || is_mul_op(op_i);
    assign busy         = (state_q == S_DIV) || (state_q == S_MUL);
`else
    logic [2*WIDTH-1:0] ext_a, ext_b, product;

    // Sign- or zero-extend to full width so the low half of the product is exact for both signednesses.
    assign ext_a    = is_signed_op(op_i) ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    assign ext_b    = is_signed_op(op_i) ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    assign product  = ext_a * ext_b;
    assign multi_op = is_div_op(op_i);
    assign busy     = (state_q == S_DIV);
`endif

    muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk            (clk),
        .rst            (rst),
        .load           (accept && is_div_op(op_i)),
        .step           (state_q == S_DIV),
        .dividend       (mag_a),
        .divisor        (mag_b),
        .quotient_next  (quo_next),
        .remainder_next (rem_next),
        .last           (div_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state: cancel aborts any busy state, DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_div_op(op_i))
                        state_d = S_DIV;
`ifdef MULDIV_ITER_MUL_EN
                    else if (is_mul_op(op_i))
                        state_d = S_MUL;
`endif
                    else
                        state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (cancel_i)
                    state_d = S_IDLE;
                else if (div_last)
                    state_d = S_DONE;
            end
`ifdef MULDIV_ITER_MUL_EN
            S_MUL: begin
                if (cancel_i)
                    state_d = S_IDLE;
                else if (mul_last)
                    state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: write strobe only in DONE, stall while busy or while a long op is being accepted.
    always_comb begin
        we_o    = 2'b00;
        stall_o = 1'b0;
        if (!rst) begin
            if (state_q == S_DONE && !cancel_i) begin
                case (op_q)
                    OP_MTHI: we_o = 2'b10;
                    OP_MTLO: we_o = 2'b01;
                    default: we_o = 2'b11;
                endcase
            end
            stall_o = busy || ((state_q == S_IDLE) && start_i && !cancel_i && multi_op);
        end
    end

    // Operand capture, sign fix-up and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
`ifdef MULDIV_ITER_MUL_EN
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
`endif
        end else begin
            if (accept) begin
                op_q       <= op_i;
                a_q        <= a_i;
                quo_neg_q  <= a_neg ^ b_neg;
                rem_neg_q  <= a_neg;
                div_zero_q <= (b_i == '0);
                case (op_i)
                    OP_MTHI: res_hi_q <= a_i;
                    OP_MTLO: res_lo_q <= a_i;
`ifdef MULDIV_ITER_MUL_EN
                    OP_MULT, OP_MULTU: begin
                        mul_acc_q    <= '0;
                        mul_mcand_q  <= {{WIDTH{1'b0}}, mag_a};
                        mul_mplier_q <= mag_b;
                        mul_cnt_q    <= CNT_W'(ITER_COUNT - 1);
                    end
`else
                    OP_MULT, OP_MULTU: {res_hi_q, res_lo_q} <= product;
`endif
                    default: ;
                endcase
            end
            if (state_q == S_DIV && div_last && !cancel_i) begin
                res_lo_q <= div_zero_q ? '1  : (quo_neg_q ? -quo_next : quo_next);
                res_hi_q <= div_zero_q ? a_q : (rem_neg_q ? -rem_next : rem_next);
            end
`ifdef MULDIV_ITER_MUL_EN
            if (state_q == S_MUL) begin
                mul_acc_q    <= mul_acc_next;
                mul_mcand_q  <= mul_mcand_q << 1;
                mul_mplier_q <= mul_mplier_q >> 1;
                if (mul_cnt_q != '0)
                    mul_cnt_q <= mul_cnt_q - 1'b1;
                if (mul_last && !cancel_i)
                    {res_hi_q, res_lo_q} <= quo_neg_q ? -mul_acc_next : mul_acc_next;
            end
`endif
        end
    end

endmodule
